// File: rtl/periph_pkg.sv
// Shared constants and types for the memory-mapped I/O controller.
package periph_pkg;

  localparam logic [7:0] OFF_LEDS    = 8'h00;
  localparam logic [7:0] OFF_SW      = 8'h04;
  localparam logic [7:0] OFF_SW_EDGE = 8'h08;
  localparam logic [7:0] OFF_CTRL    = 8'h0C;
  localparam logic [7:0] OFF_LOAD    = 8'h10;
  localparam logic [7:0] OFF_COUNT   = 8'h14;
  localparam logic [7:0] OFF_STATUS  = 8'h18;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_AR  = 1;
  localparam int unsigned CTRL_IRQ = 2;
  localparam int unsigned CTRL_W   = 3;

  // Field order matches the CTRL bit indices above (en is bit 0).
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/periph_ctrl_switch_debouncer.sv
// Two-flop synchronizer plus sampled debounce; a bit is accepted once stable over two ticks.
module switch_debouncer #(
  parameter int unsigned N_SW       = 10,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_sw,
  output logic [N_SW-1:0] o_rise_c
);
  import periph_pkg::*;

  localparam int unsigned PW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [N_SW-1:0] r_sync1;
  logic [N_SW-1:0] r_sync2;
  logic [N_SW-1:0] r_prev;
  logic [N_SW-1:0] r_sw;
  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic [N_SW-1:0] w_stable;
  logic [N_SW-1:0] w_sw_nxt;

  assign w_tick   = (r_presc == PW'(DEB_CYCLES - 1));
  assign w_stable = ~(r_sync2 ^ r_prev);
  assign w_sw_nxt = w_tick ? ((r_sync2 & w_stable) | (r_sw & ~w_stable)) : r_sw;

  // Rise is flagged combinationally so the edge register sets on the same edge SW changes.
  assign o_rise_c = w_sw_nxt & ~r_sw;
  assign o_sw     = r_sw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_sw    <= '0;
      r_presc <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_sw    <= w_sw_nxt;
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_prev <= r_sync2;
    end
  end

endmodule

// File: rtl/periph_ctrl.sv
// I/O page decoder with LED register, debounced switches with edge capture, and a down-counter timer.
module periph_ctrl #(
  parameter logic [31:0] IO_BASE    = 32'hC000_0000,
  parameter int unsigned N_SW       = 10,
  parameter int unsigned N_LED      = 10,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned TIMER_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      io_rdata,
  output logic             io_sel,
  output logic             dmem_we,
  input  logic [N_SW-1:0]  switches,
  output logic [N_LED-1:0] leds,
  output logic             irq
);
  import periph_pkg::*;

  logic [N_LED-1:0]   r_leds;
  logic [N_SW-1:0]    r_sw_edge;
  ctrl_t              r_ctrl;
  logic [TIMER_W-1:0] r_load;
  logic [TIMER_W-1:0] r_count;
  logic               r_expired;
  logic               r_irq;

  logic               w_we;
  logic [7:0]         w_off;
  logic [N_SW-1:0]    w_sw;
  logic [N_SW-1:0]    w_sw_rise;
  logic [N_SW-1:0]    w_edge_clr;
  logic               w_exp_set;
  logic               w_exp_clr;
  ctrl_t              w_ctrl_nxt;
  logic [TIMER_W-1:0] w_load_nxt;
  logic [TIMER_W-1:0] w_count_nxt;
  logic               w_unused;

  assign io_sel   = (DataAdr[31:8] == IO_BASE[31:8]);
  assign dmem_we  = MemWrite & ~io_sel;
  assign w_we     = MemWrite & io_sel;
  assign w_off    = {DataAdr[7:2], 2'b00};
  assign w_unused = ^DataAdr[1:0];
  assign leds     = r_leds;
  assign irq      = r_irq;

  switch_debouncer #(
    .N_SW       (N_SW),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk      (clk),
    .reset    (reset),
    .i_sw     (switches),
    .o_sw     (w_sw),
    .o_rise_c (w_sw_rise)
  );

  assign w_edge_clr = (w_we && w_off == OFF_SW_EDGE) ? WriteData[N_SW-1:0] : '0;
  assign w_exp_clr  = w_we && (w_off == OFF_STATUS) && WriteData[0];

  // Timer next state: count/reload/auto-clear first, then software writes take precedence.
  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_load_nxt  = r_load;
    w_count_nxt = r_count;
    w_exp_set   = 1'b0;
    if (r_ctrl.en) begin
      if (r_count != '0) begin
        w_count_nxt = r_count - TIMER_W'(1);
      end else begin
        w_exp_set = 1'b1;
        if (r_ctrl.auto_reload) w_count_nxt = r_load;
        else                    w_ctrl_nxt.en = 1'b0;
      end
    end
    if (w_we && w_off == OFF_CTRL) begin
      w_ctrl_nxt.en          = WriteData[CTRL_EN];
      w_ctrl_nxt.auto_reload = WriteData[CTRL_AR];
      w_ctrl_nxt.irq_en      = WriteData[CTRL_IRQ];
    end
    if (w_we && w_off == OFF_LOAD) begin
      w_load_nxt  = WriteData[TIMER_W-1:0];
      w_count_nxt = WriteData[TIMER_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds    <= '0;
      r_sw_edge <= '0;
      r_ctrl    <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_we && w_off == OFF_LEDS) r_leds <= WriteData[N_LED-1:0];
      r_sw_edge <= w_sw_rise | (r_sw_edge & ~w_edge_clr);
      r_ctrl    <= w_ctrl_nxt;
      r_load    <= w_load_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_exp_set | (r_expired & ~w_exp_clr);
      r_irq     <= r_expired & r_ctrl.irq_en;
    end
  end

  // Read mux over registered state; unmapped offsets read zero.
  always_comb begin
    io_rdata = '0;
    case (w_off)
      OFF_LEDS:    io_rdata = 32'(r_leds);
      OFF_SW:      io_rdata = 32'(w_sw);
      OFF_SW_EDGE: io_rdata = 32'(r_sw_edge);
      OFF_CTRL:    io_rdata = 32'(r_ctrl);
      OFF_LOAD:    io_rdata = 32'(r_load);
      OFF_COUNT:   io_rdata = 32'(r_count);
      OFF_STATUS:  io_rdata = 32'(r_expired);
      default:     io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_periph_ctrl.sv
// Directed self-checking bench for periph_ctrl with a short debounce period.
module tb_periph_ctrl;

  localparam logic [31:0] BASE = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] io_rdata;
  logic        io_sel;
  logic        dmem_we;
  logic [9:0]  switches;
  logic [9:0]  leds;
  logic        irq;

  int vectors = 0;
  int errors  = 0;

  periph_ctrl #(
    .IO_BASE    (32'hC000_0000),
    .N_SW       (10),
    .N_LED      (10),
    .DEB_CYCLES (4),
    .TIMER_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .io_rdata  (io_rdata),
    .io_sel    (io_sel),
    .dmem_we   (dmem_we),
    .switches  (switches),
    .leds      (leds),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Called from a negedge; the write lands on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemWrite = 1'b0;
    DataAdr  = a;
    #1;
    d = io_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; switches = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vectors++; if (leds !== 10'h000) begin errors++; $display("FAIL reset_leds got %h want 000", leds); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count got %h want 0", d); end
  endtask

  task automatic test_leds_decode;
    logic [31:0] d;
    MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'h2A5;
    #1;
    vectors++; if (io_sel !== 1'b1) begin errors++; $display("FAIL io_sel_hit got %b want 1", io_sel); end
    vectors++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL dmem_we_io got %b want 0", dmem_we); end
    @(negedge clk);
    MemWrite = 1'b0;
    vectors++; if (leds !== 10'h2A5) begin errors++; $display("FAIL leds_wr got %h want 2a5", leds); end
    rd(BASE, d);
    vectors++; if (d !== 32'h2A5) begin errors++; $display("FAIL leds_rd got %h want 000002a5", d); end
    MemWrite = 1'b1; DataAdr = 32'h0000_0040; WriteData = 32'h1;
    #1;
    vectors++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL dmem_we_mem got %b want 1", dmem_we); end
    @(negedge clk);
    MemWrite = 1'b0;
    vectors++; if (leds !== 10'h2A5) begin errors++; $display("FAIL leds_kept got %h want 2a5", leds); end
  endtask

  task automatic test_switches;
    logic [31:0] d;
    int n;
    switches = 10'h001;
    n = 0;
    d = '0;
    while (n < 12 && d !== 32'h1) begin
      @(negedge clk);
      n++;
      rd(BASE + 32'h04, d);
    end
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL sw_accept got %h want 1 after %0d cycles", d, n); end
    rd(BASE + 32'h08, d);
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL sw_edge_set got %h want 1", d); end
    @(negedge clk);
    switches = 10'h003;
    repeat (2) @(negedge clk);
    switches = 10'h001;
    repeat (20) @(negedge clk);
    rd(BASE + 32'h04, d);
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL sw_glitch got %h want 1", d); end
    rd(BASE + 32'h08, d);
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL sw_edge_glitch got %h want 1", d); end
    @(negedge clk);
    wr(BASE + 32'h08, 32'h1);
    rd(BASE + 32'h08, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL sw_edge_w1c got %h want 0", d); end
  endtask

  task automatic test_timer_oneshot;
    logic [31:0] d;
    @(negedge clk);
    wr(BASE + 32'h10, 32'd5);
    wr(BASE + 32'h0C, 32'h1);
    for (int k = 5; k >= 0; k--) begin
      rd(BASE + 32'h14, d);
      vectors++; if (d !== 32'(k)) begin errors++; $display("FAIL os_count got %0d want %0d", d, k); end
      rd(BASE + 32'h18, d);
      vectors++; if (d !== 32'h0) begin errors++; $display("FAIL os_early_exp got %h want 0", d); end
      @(negedge clk);
    end
    rd(BASE + 32'h18, d);
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL os_expired got %h want 1", d); end
    rd(BASE + 32'h0C, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL os_en_clr got %h want 0", d); end
    @(negedge clk);
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL os_hold got %h want 0", d); end
    wr(BASE + 32'h18, 32'h1);
    rd(BASE + 32'h18, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL os_w1c got %h want 0", d); end
  endtask

  task automatic test_timer_autoreload;
    logic [31:0] d;
    @(negedge clk);
    wr(BASE + 32'h10, 32'd3);
    wr(BASE + 32'h0C, 32'h7);
    repeat (4) @(negedge clk);
    rd(BASE + 32'h18, d);
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL ar_exp1 got %h want 1", d); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq_lag got %b want 0", irq); end
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'd3) begin errors++; $display("FAIL ar_reload got %0d want 3", d); end
    @(negedge clk);
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_irq got %b want 1", irq); end
    wr(BASE + 32'h18, 32'h1);
    rd(BASE + 32'h18, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL ar_w1c got %h want 0", d); end
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq_clr got %b want 0", irq); end
    wr(BASE + 32'h18, 32'h1);
    rd(BASE + 32'h18, d);
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL ar_set_wins got %h want 1", d); end
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'd3) begin errors++; $display("FAIL ar_reload2 got %0d want 3", d); end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] d;
    wr(BASE, 32'h3FF);
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'd2) begin errors++; $display("FAIL mid_count got %0d want 2", d); end
    vectors++; if (leds !== 10'h3FF) begin errors++; $display("FAIL mid_leds got %h want 3ff", leds); end
    reset = 1'b1;
    MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'h155;
    @(negedge clk);
    reset = 1'b0;
    MemWrite = 1'b0;
    vectors++; if (leds !== 10'h000) begin errors++; $display("FAIL rst_leds got %h want 000", leds); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count got %h want 0", d); end
    rd(BASE + 32'h0C, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h want 0", d); end
    rd(BASE + 32'h18, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", d); end
    rd(BASE + 32'h10, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_load got %h want 0", d); end
    @(negedge clk);
    rd(BASE + 32'h14, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_no_count got %h want 0", d); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    @(negedge clk);
    wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    rd(BASE + 32'h1C, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rd_1c got %h want 0", d); end
    rd(BASE + 32'hFC, d);
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rd_fc got %h want 0", d); end
    vectors++; if (leds !== 10'h000) begin errors++; $display("FAIL unmapped_leds got %h want 000", leds); end
    DataAdr = 32'hC000_0103;
    #1;
    vectors++; if (io_sel !== 1'b0) begin errors++; $display("FAIL io_sel_miss got %b want 0", io_sel); end
    wr(BASE + 32'h03, 32'h0AB);
    vectors++; if (leds !== 10'h0AB) begin errors++; $display("FAIL low_bits_ignored got %h want 0ab", leds); end
  endtask

  initial begin
    test_reset;
    @(negedge clk);
    test_leds_decode;
    test_switches;
    test_timer_oneshot;
    test_timer_autoreload;
    test_reset_midcount;
    test_unmapped;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
